rsa_req_ctrl: RTL
=================

RSA_REQ_CTRL -- requirements
Module: rsa_req_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535, meaning the maximum number of cycles spent in WAIT before aborting (1..65535).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port cfg_load  input  1  when high in IDLE, latches cfg_key and cfg_mod.
REQ-005 SHALL have ports cfg_key / cfg_mod  input  32 each  exponent and modulus.
REQ-006 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_data (input, 32)  input-text handshake.
REQ-007 SHALL have ports core_text, core_key and core_mod  output  32 each  operands driven to the RSA core.
REQ-008 SHALL have port core_go  output  1  one-cycle start pulse to the core.
REQ-009 SHALL have ports core_done (input, 1) and core_result (input, 32)  core completion and result.
REQ-010 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data (output, 32)  result handshake.
REQ-011 SHALL have ports busy (output, 1) and err_timeout (output, 1; sticky).

Function
REQ-012 SHALL implement FSM states IDLE, LAUNCH, WAIT and HOLD.
REQ-013 SHALL assert in_ready only in IDLE.
REQ-014 SHALL, in IDLE with in_valid=1, capture in_data into the text register and go to LAUNCH.
REQ-015 SHALL drive core_go=1 for exactly one cycle, in LAUNCH, i.e. the cycle after the accept, then go to WAIT.
REQ-016 SHALL hold core_text, core_key and core_mod stable from LAUNCH until the state returns to IDLE.
REQ-017 SHALL ignore core_done in IDLE, LAUNCH and HOLD; it is sampled only in WAIT.
REQ-018 SHALL, when core_done=1 in WAIT, capture core_result into out_data, clear the wait counter and go to HOLD, so out_valid rises on the next cycle.
REQ-019 SHALL assert out_valid throughout HOLD with out_data stable, and return to IDLE in the cycle out_valid and out_ready are both 1.
REQ-020 SHALL keep a 16-bit wait counter that increments each WAIT cycle; on reaching TIMEOUT_CYCLES without core_done it sets err_timeout and returns to IDLE with no output produced.
REQ-021 SHALL resolve core_done arriving on the same cycle the counter reaches TIMEOUT_CYCLES in favour of core_done (no error).
REQ-022 SHALL latch cfg_load only in IDLE; cfg_load in any other state SHALL be ignored.
REQ-023 SHALL, when cfg_load and in_valid are both 1 in IDLE, apply the new key/mod to that same transaction.
REQ-024 SHALL drive busy=1 in every state except IDLE.
REQ-025 SHALL keep err_timeout set until reset; it SHALL NOT block further transactions.

Reset
REQ-026 SHALL, on reset=1 at a clock edge in any state, enter IDLE.
REQ-027 SHALL, on reset, clear core_go, out_valid, busy and err_timeout, and set in_ready=1 on the next cycle.
REQ-028 SHALL, on reset, clear the text, key, mod and out_data registers and the wait counter to 0.
REQ-029 SHALL, when reset occurs mid-WAIT, ignore a late core_done.

Configuration
REQ-030 SHALL, when macro RSA_REQ_RANGE_CHECK_EN is defined, compare the accepted in_data against the latched mod; if in_data >= mod (including mod=0), set a sticky output err_range (1 bit, cleared by reset), skip LAUNCH and return to IDLE with no core_go.
REQ-031 SHALL, when RSA_REQ_RANGE_CHECK_EN is undefined, have no err_range port and launch every accepted word unchecked.

Verification
REQ-032 SHALL cover: load key=0xa51126c1, mod=0xae177305, text=0x00982af2; core model returns 0x12345678 after 40 cycles -> one core_go pulse 1 cycle after accept; out_valid 1 cycle after done with out_data=0x12345678.
REQ-033 SHALL cover: out_ready held low 20 cycles in HOLD -> out_valid and out_data stable; in_ready=0 throughout; IDLE the cycle after out_ready=1.
REQ-034 SHALL cover: TIMEOUT_CYCLES=100 with the core never asserting done -> err_timeout=1 after 100 WAIT cycles; no out_valid; the next transaction completes normally.
REQ-035 SHALL cover: reset at WAIT cycle 10, then core_done 5 cycles later -> state IDLE, out_valid stays 0, all outputs zero.
REQ-036 SHALL cover: with RSA_REQ_RANGE_CHECK_EN, mod=0x00000100 and text=0x00000100 -> err_range=1, no core_go; text=0x000000ff -> normal launch.
REQ-037 SHALL cover: cfg_load with a new mod during WAIT -> core_mod unchanged until the next IDLE load.

Source files
------------

// File: rtl/rsa_req_ctrl.sv
// Request controller sequencing one text word through an external RSA core.
// Optional input range check against the modulus: define RSA_REQ_RANGE_CHECK_EN.
module rsa_req_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 65535
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cfg_load,
   input  logic [31:0] cfg_key,
   input  logic [31:0] cfg_mod,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic [31:0] core_text,
   output logic [31:0] core_key,
   output logic [31:0] core_mod,
   output logic        core_go,
   input  logic        core_done,
   input  logic [31:0] core_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic        busy,
   output logic        err_timeout
`ifdef RSA_REQ_RANGE_CHECK_EN
   ,
   output logic        err_range
`endif
);

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT,
      HOLD
   } state_t;

   localparam logic [15:0] TimeoutLimit = 16'(TIMEOUT_CYCLES);

   state_t      state_q, state_d;
   logic [31:0] text_q, text_d;
   logic [31:0] key_q, key_d;
   logic [31:0] mod_q, mod_d;
   logic [31:0] out_q, out_d;
   logic [15:0] cnt_q, cnt_d;
   logic [15:0] cnt_inc;
   logic        err_to_q, err_to_d;
`ifdef RSA_REQ_RANGE_CHECK_EN
   logic        err_rng_q, err_rng_d;
   logic [31:0] mod_eff;
`endif

   assign cnt_inc = cnt_q + 16'd1;

   always_comb begin
      state_d   = state_q;
      text_d    = text_q;
      key_d     = key_q;
      mod_d     = mod_q;
      out_d     = out_q;
      cnt_d     = cnt_q;
      err_to_d  = err_to_q;
      in_ready  = 1'b0;
      core_go   = 1'b0;
      out_valid = 1'b0;
`ifdef RSA_REQ_RANGE_CHECK_EN
      err_rng_d = err_rng_q;
      // A same-cycle cfg_load applies to the word being accepted.
      mod_eff   = cfg_load ? cfg_mod : mod_q;
`endif
      unique case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (cfg_load) begin
               key_d = cfg_key;
               mod_d = cfg_mod;
            end
            if (in_valid) begin
               text_d  = in_data;
               state_d = LAUNCH;
`ifdef RSA_REQ_RANGE_CHECK_EN
               if (in_data >= mod_eff) begin
                  err_rng_d = 1'b1;
                  state_d   = IDLE;
               end
`endif
            end
         end
         LAUNCH: begin
            core_go = 1'b1;
            state_d = WAIT;
         end
         WAIT: begin
            // core_done wins over a timeout expiring in the same cycle.
            if (core_done) begin
               out_d   = core_result;
               cnt_d   = '0;
               state_d = HOLD;
            end else if (cnt_inc == TimeoutLimit) begin
               err_to_d = 1'b1;
               cnt_d    = '0;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         text_q    <= '0;
         key_q     <= '0;
         mod_q     <= '0;
         out_q     <= '0;
         cnt_q     <= '0;
         err_to_q  <= 1'b0;
`ifdef RSA_REQ_RANGE_CHECK_EN
         err_rng_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         text_q    <= text_d;
         key_q     <= key_d;
         mod_q     <= mod_d;
         out_q     <= out_d;
         cnt_q     <= cnt_d;
         err_to_q  <= err_to_d;
`ifdef RSA_REQ_RANGE_CHECK_EN
         err_rng_q <= err_rng_d;
`endif
      end
   end

   assign core_text   = text_q;
   assign core_key    = key_q;
   assign core_mod    = mod_q;
   assign out_data    = out_q;
   assign busy        = (state_q != IDLE);
   assign err_timeout = err_to_q;
`ifdef RSA_REQ_RANGE_CHECK_EN
   assign err_range   = err_rng_q;
`endif

endmodule
